// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised Mealy pattern detector.
package seq_det_pkg;

    typedef enum logic [0:0] {
        UNCFG = 1'b0,
        ARMED = 1'b1
    } seq_det_state_t;

    function automatic logic len_legal(input int unsigned len, input int unsigned pat_w);
        return (len >= 1) && (len <= pat_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; a clear coincident with an increment lands on 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= (cnt_d == '1);
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;

endmodule

// File: rtl/seq_detect_mealy_param.sv
// Mealy serial-pattern detector with a runtime-programmable pattern of 1..PAT_W bits,
// overlap/non-overlap mode and a saturating match counter.
//
//   state | meaning
//   UNCFG | no legal pattern latched; match held low
//   ARMED | pattern latched; comparing history plus incoming bit
module seq_detect_mealy_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(1),
    parameter int               DEF_LEN = 2,
    parameter logic             DEF_OVL = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_bit,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pat,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_ovl,
    input  logic                         clr_cnt,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         cnt_sat,
    output logic                         cfg_err
);

    localparam int               LEN_W   = $clog2(PAT_W + 1);
    localparam logic [LEN_W-1:0] FILL_MX = LEN_W'(PAT_W);
    localparam logic             DEF_OK  = (DEF_LEN >= 1) && (DEF_LEN <= PAT_W);

    seq_det_state_t   state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             cfg_err_q;

    logic             accept;
    logic             cfg_legal;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] mask;
    logic             fill_ok;
    logic             pat_hit;

    assign accept    = in_valid && !cfg_load;
    assign cfg_legal = len_legal(32'(cfg_len), PAT_W);
    assign window    = {hist_q[PAT_W-2:0], in_bit};

    // Only the low len_q bits of the window take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (32'(i) < 32'(len_q));
        end
    end

    assign fill_ok = (({1'b0, fill_q} + (LEN_W+1)'(1)) >= {1'b0, len_q});
    assign pat_hit = (((window ^ pat_q) & mask) == '0);
    assign match   = (state_q == ARMED) && accept && fill_ok && pat_hit;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        if (cfg_load) begin
            if (cfg_legal) begin
                state_d = ARMED;
                pat_d   = cfg_pat;
                len_d   = cfg_len;
                ovl_d   = cfg_ovl;
                hist_d  = '0;
                fill_d  = '0;
            end
        end else if (in_valid) begin
            hist_d = {hist_q[PAT_W-2:0], in_bit};
            // Non-overlap: a match consumes its bits, so the next match needs a full refill.
            if (match && !ovl_q) begin
                fill_d = '0;
            end else if (fill_q != FILL_MX) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DEF_OK ? ARMED : UNCFG;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= DEF_PAT;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVL;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_load && !cfg_legal;
        end
    end

    assign cfg_err = cfg_err_q;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (match),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// Directed bench for seq_detect_mealy_param with hand-computed match sequences.
module tb_seq_detect_mealy_param;

    localparam int PAT_W = 8;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             clr_cnt;
    logic             match;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;
    logic             cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_detect_mealy_param #(
        .PAT_W   (PAT_W),
        .CNT_W   (CNT_W),
        .DEF_PAT (8'b0000_0001),
        .DEF_LEN (2),
        .DEF_OVL (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .cfg_load  (cfg_load),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .clr_cnt   (clr_cnt),
        .match     (match),
        .match_cnt (match_cnt),
        .cnt_sat   (cnt_sat),
        .cfg_err   (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: inputs set on the falling edge, match sampled 1 ns later, then the rising edge.
    task automatic drive(input logic v, input logic b, input logic ld, input logic clr,
                         input logic exp_m, input string tag);
        @(negedge clk);
        in_valid = v;
        in_bit   = b;
        cfg_load = ld;
        clr_cnt  = clr;
        #1;
        chk(tag, 32'(match), 32'(exp_m));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        clr_cnt  = 1'b0;
    endtask

    // Bits sent MSB first; gap idle cycles (with in_bit=1) follow each bit.
    task automatic send(input string tag, input logic [31:0] bits, input logic [31:0] expm,
                        input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, bits[i], 1'b0, 1'b0, expm[i], $sformatf("%s_bit%0d", tag, n - i));
            for (int g = 0; g < gap; g++) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, $sformatf("%s_bubble%0d", tag, n - i));
            end
        end
    endtask

    // Config inputs are scrambled afterwards; they must only matter on cfg_load.
    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
        cfg_pat = p;
        cfg_len = l;
        cfg_ovl = o;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "load_match");
        cfg_pat = ~p;
        cfg_len = LEN_W'(3);
        cfg_ovl = ~o;
    endtask

    task automatic clear_cnt();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_match");
        chk("clr_cnt_zero", 32'(match_cnt), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        cfg_load = 1'b0;
        cfg_pat  = '0;
        cfg_len  = '0;
        cfg_ovl  = 1'b0;
        clr_cnt  = 1'b0;
        do_reset();

        chk("rst_cnt", 32'(match_cnt), 0);
        chk("rst_sat", 32'(cnt_sat), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_match", 32'(match), 0);

        // Defaults: pattern 01, overlap
        send("s1", 32'b0101, 32'b0101, 4, 0);
        chk("s1_cnt", 32'(match_cnt), 2);
        clear_cnt();

        // 1011 overlapping
        load(8'b1011, LEN_W'(4), 1'b1);
        send("s2", 32'b1011011, 32'b0001001, 7, 0);
        chk("s2_cnt", 32'(match_cnt), 2);
        clear_cnt();

        // 1011 non-overlapping
        load(8'b1011, LEN_W'(4), 1'b0);
        send("s3a", 32'b1011011, 32'b0001000, 7, 0);
        send("s3b", 32'b1011, 32'b0001, 4, 0);
        chk("s3_cnt", 32'(match_cnt), 2);
        clear_cnt();

        // Bubbles between bits
        load(8'b1011, LEN_W'(4), 1'b1);
        send("s4", 32'b1011011, 32'b0001001, 7, 3);
        chk("s4_cnt", 32'(match_cnt), 2);
        clear_cnt();

        // Illegal lengths leave config and history alone
        load(8'b0000_0000, LEN_W'(0), 1'b0);
        chk("s5_err_len0", 32'(cfg_err), 1);
        @(posedge clk);
        #1;
        chk("s5_err_pulse", 32'(cfg_err), 0);
        send("s5_old", 32'b1011, 32'b0001, 4, 0);
        load(8'hFF, LEN_W'(9), 1'b0);
        chk("s5_err_len9", 32'(cfg_err), 1);
        send("s5_pre", 32'b101, 32'b000, 3, 0);

        // cfg_load beats the final pattern bit and flushes history
        cfg_pat = 8'b1011;
        cfg_len = LEN_W'(4);
        cfg_ovl = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s5_prio");
        chk("s5_prio_err", 32'(cfg_err), 0);
        send("s5_flush", 32'b1011, 32'b0001, 4, 0);
        chk("s5_cnt", 32'(match_cnt), 2);
        clear_cnt();

        // len=1 saturation and clear-with-match
        load(8'b0000_0001, LEN_W'(1), 1'b1);
        send("s6", 32'hFFFFF, 32'hFFFFF, 20, 0);
        chk("s6_cnt_sat", 32'(match_cnt), 15);
        chk("s6_sat_flag", 32'(cnt_sat), 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "s6_clr_hit");
        chk("s6_clr_hit_cnt", 32'(match_cnt), 1);
        chk("s6_clr_hit_sat", 32'(cnt_sat), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s6_clr_only");
        chk("s6_clr_only_cnt", 32'(match_cnt), 0);

        // len=1 non-overlapping pattern 0
        load(8'b0000_0000, LEN_W'(1), 1'b0);
        send("s6n", 32'b010, 32'b101, 3, 0);
        chk("s6n_cnt", 32'(match_cnt), 2);

        // Reset mid-stream discards history and restores defaults
        load(8'b1011, LEN_W'(4), 1'b1);
        send("s7", 32'b101, 32'b000, 3, 0);
        do_reset();
        chk("s7_rst_cnt", 32'(match_cnt), 0);
        send("s7_post", 32'b1, 32'b0, 1, 0);
        send("s7_def", 32'b01, 32'b01, 2, 0);
        chk("s7_cnt", 32'(match_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
